instruction_fetch: RTL and testbench

- IF stage plus IF/ID pipeline register of the 5-stage MIPS core.
- Holds the PC and a loadable instruction memory, and fetches one word per cycle.
- Registers {instruction, PC+4} for the decode stage, which slices opcode [31:26] and func [5:0] for the control unit.
- Honours stall from the hazard unit, flush/redirect from branch/jump resolution, run-enable from the debug unit, and a loader write port.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/instr_mem.sv | 34 +++
 rtl/instruction_fetch.sv | 130 +++++++++++++
 tb/tb_instruction_fetch.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS core front end.
// Holds the instruction encodings the fetch stage recognises, the decode
// field positions and the PC reset value.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
  localparam logic [31:0] PC_RESET   = 32'h0000_0000;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int FUNC_MSB   = 5;
  localparam int FUNC_LSB   = 0;

  // True when the word is the end-of-program marker.
  function automatic logic is_halt_instr(input logic [31:0] word);
    return (word == HALT_INSTR);
  endfunction

endpackage

// File: rtl/instr_mem.sv
// Instruction memory: DEPTH x WIDTH words.
// Ports:
//   clk   - write clock
//   we    - write strobe; the word is written on the rising edge
//   waddr - word index for the write
//   wdata - word to write
//   raddr - word index for the asynchronous read
//   rdata - word currently stored at raddr (old value during a same-edge write)
// Contents are not reset.
module instr_mem #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Loader write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/instruction_fetch.sv
// IF stage plus IF/ID pipeline register.
// Ports:
//   i_clk, i_reset       - clock and synchronous active-high reset
//   i_enable             - debug run enable; 0 freezes every register
//   i_stall              - hazard stall; holds PC and IF/ID
//   i_flush              - squash IF/ID to a NOP bubble
//   i_redirect(_addr)    - taken branch/jump; reload the PC
//   i_load_en/addr/data  - instruction memory loader write port
//   o_pc                 - current fetch PC
//   o_instr, o_pc_plus4  - IF/ID instruction and its PC+4
//   o_valid              - IF/ID holds a real instruction
//   o_halt               - sticky: a HALT word has been fetched
module instruction_fetch
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int IMEM_DEPTH  = 256,
  parameter int IMEM_ADDR_W = 8
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_enable,
  input  logic                   i_stall,
  input  logic                   i_flush,
  input  logic                   i_redirect,
  input  logic [DATA_WIDTH-1:0]  i_redirect_addr,
  input  logic                   i_load_en,
  input  logic [IMEM_ADDR_W-1:0] i_load_addr,
  input  logic [DATA_WIDTH-1:0]  i_load_data,
  output logic [DATA_WIDTH-1:0]  o_pc,
  output logic [DATA_WIDTH-1:0]  o_instr,
  output logic [DATA_WIDTH-1:0]  o_pc_plus4,
  output logic                   o_valid,
  output logic                   o_halt
);

  localparam logic [DATA_WIDTH-1:0] PC_STEP     = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-3:0] DEPTH_WORDS = (DATA_WIDTH-2)'(IMEM_DEPTH);

  logic [DATA_WIDTH-1:0] pc_r, instr_r, pc_plus4_r;
  logic                  valid_r, halt_r;

  logic [DATA_WIDTH-1:0] pc_next_s, instr_next_s, pc_plus4_next_s;
  logic                  valid_next_s, halt_next_s;

  logic [DATA_WIDTH-1:0] pc_inc_s, mem_word_s, fetch_word_s, redirect_pc_s;
  logic                  in_range_s;
  logic                  redirect_unused_s;

  instr_mem #(
    .WIDTH  (DATA_WIDTH),
    .DEPTH  (IMEM_DEPTH),
    .ADDR_W (IMEM_ADDR_W)
  ) u_imem (
    .clk   (i_clk),
    .we    (i_load_en),
    .waddr (i_load_addr),
    .wdata (i_load_data),
    .raddr (pc_r[IMEM_ADDR_W+1:2]),
    .rdata (mem_word_s)
  );

  assign pc_inc_s      = pc_r + PC_STEP;
  // Word addresses past the end of memory fetch a NOP instead of aliasing.
  assign in_range_s    = (pc_r[DATA_WIDTH-1:2] < DEPTH_WORDS);
  assign fetch_word_s  = in_range_s ? mem_word_s : NOP_INSTR;
  // Targets are forced to word alignment; the low byte-offset bits are dropped.
  assign redirect_pc_s = {i_redirect_addr[DATA_WIDTH-1:2], 2'b00};
  assign redirect_unused_s = ^i_redirect_addr[1:0];

  // Next-state selection in control priority order.
  always_comb begin
    pc_next_s       = pc_r;
    instr_next_s    = instr_r;
    pc_plus4_next_s = pc_plus4_r;
    valid_next_s    = valid_r;
    halt_next_s     = halt_r;
    if (!i_enable) begin
      pc_next_s = pc_r;
    end else if (i_redirect) begin
      pc_next_s       = redirect_pc_s;
      instr_next_s    = NOP_INSTR;
      pc_plus4_next_s = '0;
      valid_next_s    = 1'b0;
      halt_next_s     = 1'b0;
    end else if (i_flush) begin
      pc_next_s       = i_stall ? pc_r : pc_inc_s;
      instr_next_s    = NOP_INSTR;
      pc_plus4_next_s = '0;
      valid_next_s    = 1'b0;
    end else if (i_stall) begin
      pc_next_s = pc_r;
    end else if (halt_r) begin
      // Halted: keep the PC parked and feed bubbles downstream.
      instr_next_s    = NOP_INSTR;
      pc_plus4_next_s = '0;
      valid_next_s    = 1'b0;
    end else begin
      pc_next_s       = pc_inc_s;
      instr_next_s    = fetch_word_s;
      pc_plus4_next_s = pc_inc_s;
      valid_next_s    = 1'b1;
      halt_next_s     = is_halt_instr(fetch_word_s);
    end
  end

  // PC, IF/ID and halt flag registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc_r       <= PC_RESET;
      instr_r    <= NOP_INSTR;
      pc_plus4_r <= '0;
      valid_r    <= 1'b0;
      halt_r     <= 1'b0;
    end else begin
      pc_r       <= pc_next_s;
      instr_r    <= instr_next_s;
      pc_plus4_r <= pc_plus4_next_s;
      valid_r    <= valid_next_s;
      halt_r     <= halt_next_s;
    end
  end

  assign o_pc       = pc_r;
  assign o_instr    = instr_r;
  assign o_pc_plus4 = pc_plus4_r;
  assign o_valid    = valid_r;
  assign o_halt     = halt_r;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset, enable, stall, flush, redirect, load_en;
  logic [31:0] redirect_addr, load_data;
  logic [7:0]  load_addr;
  logic [31:0] pc, instr, pc_plus4;
  logic        valid, halt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  logic [31:0] mem_m [256];
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_halt;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_enable        (enable),
    .i_stall         (stall),
    .i_flush         (flush),
    .i_redirect      (redirect),
    .i_redirect_addr (redirect_addr),
    .i_load_en       (load_en),
    .i_load_addr     (load_addr),
    .i_load_data     (load_data),
    .o_pc            (pc),
    .o_instr         (instr),
    .o_pc_plus4      (pc_plus4),
    .o_valid         (valid),
    .o_halt          (halt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock: update the reference from the current inputs, then compare.
  task automatic cycle();
    logic [31:0] fetched;
    logic        squash;
    squash  = 1'b0;
    fetched = (m_pc[31:2] < 30'd256) ? mem_m[m_pc[9:2]] : 32'h0;
    if (reset) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_halt = 1'b0;
    end else if (enable) begin
      if (redirect) begin
        m_pc = redirect_addr & 32'hFFFF_FFFC; squash = 1'b1; m_halt = 1'b0;
      end else if (flush) begin
        if (!stall) m_pc = m_pc + 32'd4;
        squash = 1'b1;
      end else if (!stall) begin
        if (m_halt) squash = 1'b1;
        else begin
          m_pc    = m_pc + 32'd4;
          m_instr = fetched;
          m_pc4   = m_pc;
          m_valid = 1'b1;
          if (fetched == 32'hFFFF_FFFF) m_halt = 1'b1;
        end
      end
      if (squash) begin
        m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      end
    end
    if (load_en) mem_m[load_addr] = load_data;
    @(posedge clk);
    #1;
    check_eq("pc",       pc,                m_pc);
    check_eq("instr",    instr,             m_instr);
    check_eq("pc_plus4", pc_plus4,          m_pc4);
    check_eq("valid",    {31'd0, valid},    {31'd0, m_valid});
    check_eq("halt",     {31'd0, halt},     {31'd0, m_halt});
  endtask

  task automatic do_redirect(input logic [31:0] addr);
    redirect = 1'b1; redirect_addr = addr;
    cycle();
    redirect = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    reset = 1'b1; enable = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0;
    redirect_addr = 32'h0; load_en = 1'b0; load_addr = 8'h0; load_data = 32'h0;
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_halt = 1'b0;
    for (int i = 0; i < 256; i++) mem_m[i] = 32'h0;

    // Fill the whole memory while in reset
    for (int i = 0; i < 256; i++) begin
      case (i)
        0:       w = 32'h2001_0005;
        1:       w = 32'h2002_0007;
        2:       w = 32'h0022_1821;
        3:       w = 32'hFFFF_FFFF;
        16:      w = 32'h8C22_0010;
        default: begin
          w = $urandom;
          if (w == 32'hFFFF_FFFF) w = 32'h1234_5678;
        end
      endcase
      load_en = 1'b1; load_addr = i[7:0]; load_data = w;
      cycle();
    end
    load_en = 1'b0;
    check_eq("reset_pc", pc, 32'h0);
    check_eq("reset_valid", {31'd0, valid}, 32'd0);

    // Sequential fetch through HALT
    reset = 1'b0;
    cycle(); check_eq("seq_i0", instr, 32'h2001_0005); check_eq("seq_p0", pc_plus4, 32'd4);
    cycle(); check_eq("seq_i1", instr, 32'h2002_0007); check_eq("seq_p1", pc_plus4, 32'd8);
    cycle(); check_eq("seq_i2", instr, 32'h0022_1821); check_eq("seq_p2", pc_plus4, 32'd12);
    cycle(); check_eq("seq_i3", instr, 32'hFFFF_FFFF); check_eq("seq_p3", pc_plus4, 32'd16);
    check_eq("seq_halt", {31'd0, halt}, 32'd1);
    cycle(); check_eq("halt_pc", pc, 32'd16); check_eq("halt_valid", {31'd0, valid}, 32'd0);
    cycle(); check_eq("halt_pc2", pc, 32'd16);

    // Stall at pc=8
    do_redirect(32'h0);
    cycle(); cycle();
    check_eq("pre_stall_pc", pc, 32'd8);
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cycle();
      check_eq("stall_pc", pc, 32'd8);
      check_eq("stall_instr", instr, 32'h2002_0007);
      check_eq("stall_valid", {31'd0, valid}, 32'd1);
    end
    stall = 1'b0;
    cycle(); check_eq("post_stall_i", instr, 32'h0022_1821); check_eq("post_stall_p", pc_plus4, 32'd12);

    // Redirect beats stall
    do_redirect(32'h4);
    cycle(); check_eq("rvs_pre_pc", pc, 32'd8);
    stall = 1'b1;
    do_redirect(32'h0000_0043);
    stall = 1'b0;
    check_eq("rvs_pc", pc, 32'h40); check_eq("rvs_instr", instr, 32'h0);
    check_eq("rvs_valid", {31'd0, valid}, 32'd0);
    cycle(); check_eq("rvs_w16", instr, 32'h8C22_0010);

    // Flush alone
    do_redirect(32'h4);
    flush = 1'b1; cycle(); flush = 1'b0;
    check_eq("flush_instr", instr, 32'h0); check_eq("flush_valid", {31'd0, valid}, 32'd0);
    check_eq("flush_pc", pc, 32'd8);

    // Out of range, then freeze
    do_redirect(32'h400);
    cycle();
    check_eq("oor_instr", instr, 32'h0); check_eq("oor_valid", {31'd0, valid}, 32'd1);
    check_eq("oor_pc", pc, 32'h404);
    enable = 1'b0; redirect = 1'b1; redirect_addr = 32'h0; flush = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check_eq("frz_pc", pc, 32'h404); check_eq("frz_p4", pc_plus4, 32'h404);
      check_eq("frz_valid", {31'd0, valid}, 32'd1); check_eq("frz_instr", instr, 32'h0);
    end
    enable = 1'b1; redirect = 1'b0; flush = 1'b0;

    // PC wrap
    do_redirect(32'hFFFF_FFFF);
    check_eq("wrap_pc0", pc, 32'hFFFF_FFFC);
    cycle(); check_eq("wrap_pc", pc, 32'h0); check_eq("wrap_p4", pc_plus4, 32'h0);
    check_eq("wrap_valid", {31'd0, valid}, 32'd1);

    // Reset mid-halt with concurrent load
    for (int k = 0; k < 5; k++) cycle();
    check_eq("mh_halt", {31'd0, halt}, 32'd1);
    reset = 1'b1; load_en = 1'b1; load_addr = 8'd5; load_data = 32'h3C01_ABCD;
    cycle();
    reset = 1'b0; load_en = 1'b0;
    check_eq("rst_pc", pc, 32'h0); check_eq("rst_halt", {31'd0, halt}, 32'd0);
    check_eq("rst_valid", {31'd0, valid}, 32'd0);
    do_redirect(32'h14);
    cycle(); check_eq("rst_load", instr, 32'h3C01_ABCD);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      reset     = ($urandom_range(0, 99) < 2);
      enable    = ($urandom_range(0, 99) < 90);
      stall     = ($urandom_range(0, 99) < 15);
      flush     = ($urandom_range(0, 99) < 8);
      redirect  = ($urandom_range(0, 99) < 8);
      redirect_addr = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom_range(0, 270) * 4 + $urandom_range(0, 3));
      load_en   = ($urandom_range(0, 99) < 20);
      load_addr = 8'($urandom_range(0, 255));
      load_data = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : $urandom;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
